// File: rtl/pd_txsched_if.sv
// PHY-side bundle of the USBPD TX scheduler.
// master: tx_req/tx_auto/tx_shrt out; ptx_txact/ptx_goidle/rx_busy/rx_gcrc in.
interface pd_txsched_if;
  logic       tx_req;
  logic [6:0] tx_auto;
  logic       tx_shrt;
  logic       ptx_txact;
  logic       ptx_goidle;
  logic       rx_busy;
  logic       rx_gcrc;

  modport master (
    output tx_req, tx_auto, tx_shrt,
    input  ptx_txact, ptx_goidle, rx_busy, rx_gcrc
  );

  modport slave (
    input  tx_req, tx_auto, tx_shrt,
    output ptx_txact, ptx_goidle, rx_busy, rx_gcrc
  );
endinterface

// File: rtl/pd_txsched.sv
// USBPD TX scheduler: fixed-priority arbitration of rst/msg/bist requests,
// inter-frame gap, TX start, end-of-frame wait, GoodCRC wait with retries.
// Ports: clk, arst (async, active high); rst_req/rst_cbl, msg_req/msg_sop,
// bist_req in; gnt {bist,msg,rst}, done pulse, sts out; phy = PHY bundle.
module pd_txsched #(
  parameter int IFG_CYC = 25,
  parameter int CRC_TO  = 1200,
  parameter int N_RETRY = 2
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         rst_req,
  input  logic         rst_cbl,
  input  logic         msg_req,
  input  logic [2:0]   msg_sop,
  input  logic         bist_req,
  output logic [2:0]   gnt,
  output logic         done,
  output logic [1:0]   sts,
  pd_txsched_if.master phy
);

  localparam int GW = $clog2(IFG_CYC + 1);
  localparam int TW = $clog2(CRC_TO + 1);
  localparam int RW = $clog2(N_RETRY + 2);

  localparam logic [GW-1:0] GLAST = GW'(IFG_CYC - 1);
  localparam logic [TW-1:0] TLAST = TW'(CRC_TO - 1);
  localparam logic [RW-1:0] RMAX  = RW'(N_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GAP,
    S_START,
    S_SEND,
    S_WCRC,
    S_DONE
  } state_t;

  state_t        state;
  logic [2:0]    src;
  logic [GW-1:0] gapcnt;
  logic [TW-1:0] tocnt;
  logic [RW-1:0] retry;
  logic          rst_pend;
  logic          rst_q;
  logic          tx_req_q;
  logic [6:0]    tx_auto_q;

  logic [2:0] sel;
  logic [6:0] auto_sel;
  logic       sop_ok;
  logic       bad_msg;
  logic       line_idle;
  logic       cur_req;
  logic       preempt;
  logic       rst_rise;

  always_comb begin
    sel = 3'b000;
    if (rst_req)
      sel = 3'b001;
    else if (msg_req)
      sel = 3'b010;
    else if (bist_req)
      sel = 3'b100;
  end

  always_comb begin
    auto_sel = 7'h08;
    if (sel[0])
      auto_sel = rst_cbl ? 7'h4F : 7'h4E;
    else if (sel[1])
      auto_sel = 7'h78 | {4'b0000, msg_sop};
  end

  assign sop_ok    = (msg_sop != 3'd0) && (msg_sop <= 3'd5);
  assign bad_msg   = sel[1] & ~sop_ok;
  assign line_idle = ~phy.rx_busy & ~phy.ptx_txact;
  assign cur_req   = |(src & {bist_req, msg_req, rst_req});
  // one-hot with rst in bit 0: a numerically lower grant wins
  assign preempt   = (sel != 3'b000) && (sel < src);
  assign rst_rise  = rst_req & ~rst_q;

  assign phy.tx_req  = tx_req_q;
  assign phy.tx_auto = tx_auto_q;
  assign phy.tx_shrt = 1'b0;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= S_IDLE;
      src       <= '0;
      gnt       <= '0;
      done      <= 1'b0;
      sts       <= '0;
      tx_req_q  <= 1'b0;
      tx_auto_q <= '0;
      gapcnt    <= '0;
      tocnt     <= '0;
      retry     <= '0;
      rst_pend  <= 1'b0;
      rst_q     <= 1'b0;
    end else begin
      done     <= 1'b0;
      tx_req_q <= 1'b0;
      rst_q    <= rst_req;
      unique case (state)
        S_IDLE: begin
          rst_pend <= 1'b0;
          gapcnt   <= '0;
          retry    <= '0;
          if (sel != 3'b000) begin
            src       <= sel;
            tx_auto_q <= auto_sel;
            if (bad_msg) begin
              sts   <= 2'd2;
              state <= S_DONE;
            end else begin
              state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (!cur_req) begin
            gnt   <= '0;
            state <= S_IDLE;
          end else begin
            if (!line_idle)
              gapcnt <= '0;
            else if (gapcnt == GLAST)
              state <= S_START;
            else
              gapcnt <= gapcnt + 1'b1;
            // a discarded preempting message overrides the start
            if (preempt) begin
              src       <= sel;
              tx_auto_q <= auto_sel;
              retry     <= '0;
              if (bad_msg) begin
                sts   <= 2'd2;
                state <= S_DONE;
              end
            end
          end
        end
        S_START: begin
          tx_req_q <= 1'b1;
          gnt      <= src;
          state    <= S_SEND;
        end
        S_SEND: begin
          if (rst_rise)
            rst_pend <= 1'b1;
          if (phy.ptx_goidle) begin
            if (src[1]) begin
              tocnt <= '0;
              state <= S_WCRC;
            end else begin
              sts   <= 2'd0;
              state <= S_DONE;
            end
          end
        end
        S_WCRC: begin
          if (phy.rx_gcrc) begin
            sts   <= 2'd0;
            state <= S_DONE;
          end else if (rst_pend | rst_req) begin
            sts   <= 2'd2;
            state <= S_DONE;
          end else if (tocnt == TLAST) begin
            if (retry < RMAX) begin
              retry  <= retry + 1'b1;
              gapcnt <= '0;
              state  <= S_GAP;
            end else begin
              sts   <= 2'd1;
              state <= S_DONE;
            end
          end else begin
            tocnt <= tocnt + 1'b1;
          end
        end
        S_DONE: begin
          done     <= 1'b1;
          gnt      <= '0;
          rst_pend <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pd_txsched.sv
// Self-checking bench for pd_txsched with randomized stimulus and
// a spec-level model of latency, tx_auto, status and gap timing.
module tb_pd_txsched;
  localparam int IFG = 25;
  localparam int CTO = 1200;
  localparam int NR  = 2;

  logic       clk = 1'b0;
  logic       arst;
  logic       rst_req;
  logic       rst_cbl;
  logic       msg_req;
  logic [2:0] msg_sop;
  logic       bist_req;
  logic [2:0] gnt;
  logic       done;
  logic [1:0] sts;

  pd_txsched_if phy();

  pd_txsched #(
    .IFG_CYC(IFG),
    .CRC_TO (CTO),
    .N_RETRY(NR)
  ) dut (
    .clk     (clk),
    .arst    (arst),
    .rst_req (rst_req),
    .rst_cbl (rst_cbl),
    .msg_req (msg_req),
    .msg_sop (msg_sop),
    .bist_req(bist_req),
    .gnt     (gnt),
    .done    (done),
    .sts     (sts),
    .phy     (phy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int txreq_cnt = 0;
  int done_cnt = 0;
  int idle_run = 0;
  int run_before = 0;

  always @(negedge clk) begin
    if (phy.tx_req === 1'b1) txreq_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  // consecutive idle-line samples, as seen by the edge before the latest
  always @(posedge clk) begin
    run_before = idle_run;
    if (phy.rx_busy || phy.ptx_txact) idle_run = 0;
    else idle_run++;
  end

  function automatic logic [6:0] exp_auto(input int s, input logic cbl,
                                          input logic [2:0] sop);
    case (s)
      0: return cbl ? 7'h4F : 7'h4E;
      1: return 7'h78 | {4'h0, sop};
      default: return 7'h08;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input int maxc, output int n);
    n = -1;
    for (int i = 0; i < maxc && n < 0; i++) begin
      tick();
      if (phy.tx_req === 1'b1) n = i;
    end
  endtask

  task automatic phy_frame(input int len);
    phy.ptx_txact = 1'b1;
    repeat (len) tick();
    phy.ptx_txact = 1'b0;
    phy.ptx_goidle = 1'b1;
    tick();
    phy.ptx_goidle = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    repeat (2) tick();
    checks++;
    if (gnt !== 3'b000) begin
      errors++; $display("FAIL rst_gnt got %b exp 000", gnt);
    end
    checks++;
    if (done !== 1'b0 || sts !== 2'd0) begin
      errors++; $display("FAIL rst_done_sts got %b/%0d exp 0/0", done, sts);
    end
    checks++;
    if (phy.tx_req !== 1'b0 || phy.tx_auto !== 7'h00) begin
      errors++;
      $display("FAIL rst_tx got %b/%h exp 0/00", phy.tx_req, phy.tx_auto);
    end
    checks++;
    if (phy.tx_shrt !== 1'b0) begin
      errors++; $display("FAIL rst_shrt got %b exp 0", phy.tx_shrt);
    end
    arst = 1'b0;
    tick();
  endtask

  task automatic test_msg_ok();
    logic [2:0] sop;
    int dly, n;
    for (int it = 0; it < 3; it++) begin
      sop = 3'($urandom_range(1, 5));
      dly = (it == 0) ? 100 : $urandom_range(1, CTO - 1);
      msg_sop = sop;
      msg_req = 1'b1;
      wait_tx(IFG + 50, n);
      checks++;
      if (n != IFG + 1) begin
        errors++; $display("FAIL msg_lat got %0d exp %0d", n, IFG + 1);
      end
      checks++;
      if (phy.tx_auto !== exp_auto(1, 1'b0, sop)) begin
        errors++;
        $display("FAIL msg_auto got %h exp %h", phy.tx_auto,
                 exp_auto(1, 1'b0, sop));
      end
      checks++;
      if (gnt !== 3'b010 || phy.tx_shrt !== 1'b0) begin
        errors++;
        $display("FAIL msg_gnt got %b/%b exp 010/0", gnt, phy.tx_shrt);
      end
      phy_frame($urandom_range(5, 40));
      repeat (dly - 1) tick();
      phy.rx_gcrc = 1'b1;
      tick();
      phy.rx_gcrc = 1'b0;
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("FAIL msg_early_done got %b exp 0", done);
      end
      tick();
      checks++;
      if (done !== 1'b1 || sts !== 2'd0 || gnt !== 3'b000) begin
        errors++;
        $display("FAIL msg_done got %b/%0d/%b exp 1/0/000", done, sts, gnt);
      end
      msg_req = 1'b0;
      repeat (3) tick();
    end
  endtask

  task automatic test_bad_sop();
    logic [2:0] bad [3];
    int c0;
    bad[0] = 3'd0;
    bad[1] = 3'd6;
    bad[2] = 3'd7;
    for (int i = 0; i < 3; i++) begin
      c0 = txreq_cnt;
      msg_sop = bad[i];
      msg_req = 1'b1;
      tick();
      tick();
      checks++;
      if (done !== 1'b1 || sts !== 2'd2 || gnt !== 3'b000) begin
        errors++;
        $display("FAIL bad_sop%0d got %b/%0d/%b exp 1/2/000",
                 bad[i], done, sts, gnt);
      end
      msg_req = 1'b0;
      repeat (IFG + 5) tick();
      checks++;
      if (txreq_cnt != c0) begin
        errors++; $display("FAIL bad_sop_tx got %0d exp %0d", txreq_cnt, c0);
      end
    end
  endtask

  task automatic test_drop_in_gap();
    int c0, d0;
    c0 = txreq_cnt;
    d0 = done_cnt;
    msg_sop = 3'd1;
    msg_req = 1'b1;
    repeat ($urandom_range(1, IFG - 1)) tick();
    msg_req = 1'b0;
    repeat (IFG + 10) tick();
    checks++;
    if (txreq_cnt != c0 || done_cnt != d0 || gnt !== 3'b000) begin
      errors++;
      $display("FAIL drop_gap got tx%0d done%0d gnt%b exp tx%0d done%0d 000",
               txreq_cnt, done_cnt, gnt, c0, d0);
    end
  endtask

  task automatic test_busy_gap();
    int busy_at [200];
    int phase, exp_e, seen, ok;
    phase = $urandom_range(0, 19);
    for (int e = 0; e < 200; e++)
      busy_at[e] = (e < 100 && ((e % 20) == phase ||
                    $urandom_range(0, 29) == 0)) ? 1 : 0;
    // start follows the first window of IFG idle edges after selection
    exp_e = -1;
    for (int k = IFG + 1; k < 200 && exp_e < 0; k++) begin
      ok = 1;
      for (int j = k - IFG; j < k; j++)
        if (busy_at[j] != 0) ok = 0;
      if (ok != 0) exp_e = k;
    end
    msg_sop = 3'($urandom_range(1, 5));
    msg_req = 1'b1;
    seen = -1;
    for (int e = 0; e < 200 && seen < 0; e++) begin
      phy.rx_busy = busy_at[e][0];
      tick();
      if (phy.tx_req === 1'b1) seen = e;
    end
    phy.rx_busy = 1'b0;
    checks++;
    if (seen != exp_e) begin
      errors++; $display("FAIL busy_gap got %0d exp %0d", seen, exp_e);
    end
    phy_frame(10);
    phy.rx_gcrc = 1'b1;
    tick();
    phy.rx_gcrc = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1 || sts !== 2'd0) begin
      errors++; $display("FAIL busy_done got %b/%0d exp 1/0", done, sts);
    end
    msg_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_priority();
    logic cbl;
    logic [2:0] sop;
    int n;
    cbl = 1'($urandom_range(0, 1));
    sop = 3'($urandom_range(1, 5));
    rst_cbl = cbl;
    msg_sop = sop;
    rst_req = 1'b1;
    msg_req = 1'b1;
    bist_req = 1'b1;
    wait_tx(IFG + 50, n);
    checks++;
    if (gnt !== 3'b001 || phy.tx_auto !== exp_auto(0, cbl, sop)) begin
      errors++;
      $display("FAIL pri_rst got %b/%h exp 001/%h", gnt, phy.tx_auto,
               exp_auto(0, cbl, sop));
    end
    phy_frame($urandom_range(5, 30));
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL pri_rst_early got %b exp 0", done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || sts !== 2'd0) begin
      errors++; $display("FAIL pri_rst_done got %b/%0d exp 1/0", done, sts);
    end
    rst_req = 1'b0;
    wait_tx(IFG + 50, n);
    checks++;
    if (n != IFG + 1 || gnt !== 3'b010 ||
        phy.tx_auto !== exp_auto(1, cbl, sop)) begin
      errors++;
      $display("FAIL pri_msg got %0d/%b/%h exp %0d/010/%h", n, gnt,
               phy.tx_auto, IFG + 1, exp_auto(1, cbl, sop));
    end
    phy_frame(8);
    phy.rx_gcrc = 1'b1;
    tick();
    phy.rx_gcrc = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1 || sts !== 2'd0) begin
      errors++; $display("FAIL pri_msg_done got %b/%0d exp 1/0", done, sts);
    end
    msg_req = 1'b0;
    wait_tx(IFG + 50, n);
    checks++;
    if (gnt !== 3'b100 || phy.tx_auto !== exp_auto(2, cbl, sop)) begin
      errors++;
      $display("FAIL pri_bist got %b/%h exp 100/08", gnt, phy.tx_auto);
    end
    phy_frame(8);
    tick();
    checks++;
    if (done !== 1'b1 || sts !== 2'd0) begin
      errors++; $display("FAIL pri_bist_done got %b/%0d exp 1/0", done, sts);
    end
    bist_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_rst_in_wcrc();
    int n;
    msg_sop = 3'($urandom_range(1, 5));
    msg_req = 1'b1;
    wait_tx(IFG + 50, n);
    phy_frame(12);
    repeat ($urandom_range(0, 50)) tick();
    rst_cbl = 1'b0;
    rst_req = 1'b1;
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || sts !== 2'd2) begin
      errors++; $display("FAIL wcrc_rst got %b/%0d exp 1/2", done, sts);
    end
    msg_req = 1'b0;
    wait_tx(IFG + 50, n);
    checks++;
    if (n < 0 || gnt !== 3'b001 ||
        phy.tx_auto !== exp_auto(0, 1'b0, 3'd0)) begin
      errors++;
      $display("FAIL wcrc_next got %0d/%b/%h exp tx/001/4e",
               n, gnt, phy.tx_auto);
    end
    phy_frame(6);
    tick();
    checks++;
    if (done !== 1'b1 || sts !== 2'd0) begin
      errors++; $display("FAIL wcrc_rst_done got %b/%0d exp 1/0", done, sts);
    end
    rst_req = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_gcrc_timeout();
    int n, c0;
    c0 = txreq_cnt;
    msg_sop = 3'd4;
    msg_req = 1'b1;
    wait_tx(IFG + 50, n);
    phy_frame(10);
    repeat (CTO - 1) tick();
    phy.rx_gcrc = 1'b1;
    tick();
    phy.rx_gcrc = 1'b0;
    tick();
    checks++;
    if (done !== 1'b1 || sts !== 2'd0) begin
      errors++; $display("FAIL to_gcrc got %b/%0d exp 1/0", done, sts);
    end
    msg_req = 1'b0;
    repeat (IFG + 5) tick();
    checks++;
    if (txreq_cnt != c0 + 1) begin
      errors++;
      $display("FAIL to_gcrc_tx got %0d exp %0d", txreq_cnt, c0 + 1);
    end
  endtask

  task automatic test_retry();
    int n, c0;
    c0 = txreq_cnt;
    msg_sop = 3'd2;
    msg_req = 1'b1;
    for (int a = 0; a <= NR; a++) begin
      wait_tx(CTO + IFG + 50, n);
      checks++;
      if (n < 0 || run_before < IFG || gnt !== 3'b010) begin
        errors++;
        $display("FAIL retry%0d got n%0d idle%0d gnt%b exp tx/>=%0d/010",
                 a, n, run_before, gnt, IFG);
      end
      phy_frame($urandom_range(5, 40));
    end
    repeat (CTO) tick();
    checks++;
    if (done !== 1'b0 || gnt !== 3'b010) begin
      errors++;
      $display("FAIL retry_early got %b/%b exp 0/010", done, gnt);
    end
    tick();
    checks++;
    if (done !== 1'b1 || sts !== 2'd1) begin
      errors++; $display("FAIL retry_fail got %b/%0d exp 1/1", done, sts);
    end
    msg_req = 1'b0;
    repeat (3) tick();
    checks++;
    if (txreq_cnt != c0 + NR + 1) begin
      errors++;
      $display("FAIL retry_cnt got %0d exp %0d", txreq_cnt - c0, NR + 1);
    end
  endtask

  task automatic test_arst_send();
    int n, d0;
    msg_sop = 3'd1;
    msg_req = 1'b1;
    wait_tx(IFG + 50, n);
    phy.ptx_txact = 1'b1;
    repeat (3) tick();
    d0 = done_cnt;
    #2 arst = 1'b1;
    #1;
    checks++;
    if (gnt !== 3'b000 || phy.tx_auto !== 7'h00) begin
      errors++;
      $display("FAIL arst_async got %b/%h exp 000/00", gnt, phy.tx_auto);
    end
    phy.ptx_txact = 1'b0;
    msg_req = 1'b0;
    repeat (2) tick();
    arst = 1'b0;
    repeat (IFG + 5) tick();
    checks++;
    if (done_cnt != d0 || gnt !== 3'b000) begin
      errors++;
      $display("FAIL arst_nodone got %0d/%b exp %0d/000", done_cnt, gnt, d0);
    end
  endtask

  initial begin
    arst = 1'b1;
    rst_req = 1'b0;
    rst_cbl = 1'b0;
    msg_req = 1'b0;
    msg_sop = 3'd0;
    bist_req = 1'b0;
    phy.ptx_txact = 1'b0;
    phy.ptx_goidle = 1'b0;
    phy.rx_busy = 1'b0;
    phy.rx_gcrc = 1'b0;
    test_reset();
    test_msg_ok();
    test_bad_sop();
    test_drop_in_gap();
    test_busy_gap();
    test_priority();
    test_rst_in_wcrc();
    test_gcrc_timeout();
    test_retry();
    test_arst_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
